input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer_pkg.sv | 16 +
 rtl/debounce_channel.sv | 60 ++++++
 rtl/input_debouncer.sv | 47 ++++
 tb/tb_input_debouncer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// rtl/input_debouncer_pkg.sv - shared constants for the pushbutton/switch debouncer
package input_debouncer_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int unsigned NUM_CHANNELS            = 4;

  localparam int unsigned CH_SET    = 0;
  localparam int unsigned CH_UNLOCK = 1;
  localparam int unsigned CH_SEL0   = 2;

  // Counter only has to reach cycles-1, so clog2(cycles) bits always suffice.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounce lane: 2-flop sync, run counter, stable level, rise strobe
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             rise_q;
  logic             rise_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any agreement with the stable value restarts the run; the counter never wraps.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - four independent debounced inputs: set, unlock and two select switches
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_btn,
  input  logic       unlock_btn,
  input  logic [1:0] sel_sw,
  output logic       set_pulse,
  output logic       unlock_pulse,
  output logic       set_level,
  output logic       unlock_level,
  output logic [1:0] sel_clean
);

  logic [NUM_CHANNELS-1:0] raw;
  logic [NUM_CHANNELS-1:0] level;
  logic [NUM_CHANNELS-1:0] rise;
  logic                    sel_rise_unused;

  assign raw = {sel_sw, unlock_btn, set_btn};

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (raw[g]),
      .level_o(level[g]),
      .rise_o (rise[g])
    );
  end

  // Slide switches are levels only; their press strobes have no consumer.
  assign sel_rise_unused = ^rise[CH_SEL0+1:CH_SEL0];

  assign set_pulse    = rise[CH_SET];
  assign unlock_pulse = rise[CH_UNLOCK];
  assign set_level    = level[CH_SET];
  assign unlock_level = level[CH_UNLOCK];
  assign sel_clean    = level[CH_SEL0+1:CH_SEL0];

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed bench for input_debouncer with DEBOUNCE_CYCLES=4
module tb_input_debouncer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       set_btn;
  logic       unlock_btn;
  logic [1:0] sel_sw;
  logic       set_pulse;
  logic       unlock_pulse;
  logic       set_level;
  logic       unlock_level;
  logic [1:0] sel_clean;

  int n_pass  = 0;
  int n_total = 0;
  int set_cnt = 0;
  int unl_cnt = 0;

  input_debouncer #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_btn     (set_btn),
    .unlock_btn  (unlock_btn),
    .sel_sw      (sel_sw),
    .set_pulse   (set_pulse),
    .unlock_pulse(unlock_pulse),
    .set_level   (set_level),
    .unlock_level(unlock_level),
    .sel_clean   (sel_clean)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, ending on the falling edge; tally strobes seen.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      set_cnt += int'(set_pulse);
      unl_cnt += int'(unlock_pulse);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n      = 1'b0;
    set_btn    = 1'b0;
    unlock_btn = 1'b0;
    sel_sw     = 2'b00;
    step(2);
    check("rst_set_level", set_level, 0);
    check("rst_unlock_level", unlock_level, 0);
    check("rst_pulses", {set_pulse, unlock_pulse}, 0);
    check("rst_sel_clean", sel_clean, 0);
    rst_n = 1'b1;
    step(3);

    // Clean press held 20 cycles.
    set_cnt = 0;
    set_btn = 1'b1;
    step(5);
    check("clean_level_edge5", set_level, 0);
    check("clean_pulse_edge5", set_cnt, 0);
    step(1);
    check("clean_level_edge6", set_level, 1);
    check("clean_pulse_edge6", set_pulse, 1);
    step(1);
    check("clean_pulse_edge7", set_pulse, 0);
    step(13);
    check("clean_pulse_total", set_cnt, 1);
    set_btn = 1'b0;
    step(5);
    check("clean_release_edge5", set_level, 1);
    step(1);
    check("clean_release_edge6", set_level, 0);
    check("clean_release_nopulse", set_cnt, 1);
    step(4);

    // Bounce 1,0,1,0 then hold.
    set_cnt = 0;
    set_btn = 1'b1; step(1);
    set_btn = 1'b0; step(1);
    set_btn = 1'b1; step(1);
    set_btn = 1'b0; step(1);
    set_btn = 1'b1;
    step(5);
    check("bounce_no_early_pulse", set_cnt, 0);
    check("bounce_level_edge5", set_level, 0);
    step(1);
    check("bounce_pulse_edge6", set_pulse, 1);
    step(3);
    check("bounce_pulse_total", set_cnt, 1);
    set_btn = 1'b0;
    step(8);

    // Three-cycle glitch on unlock.
    unl_cnt = 0;
    unlock_btn = 1'b1;
    step(3);
    unlock_btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("glitch_unlock_level", unlock_level, 0);
    end
    check("glitch_unlock_pulses", unl_cnt, 0);

    // Simultaneous press.
    set_cnt = 0;
    unl_cnt = 0;
    set_btn    = 1'b1;
    unlock_btn = 1'b1;
    step(5);
    check("simul_none_edge5", {set_pulse, unlock_pulse}, 2'b00);
    step(1);
    check("simul_both_edge6", {set_pulse, unlock_pulse}, 2'b11);
    set_btn = 1'b0;
    step(8);
    check("simul_pulse_counts", {set_cnt[7:0], unl_cnt[7:0]}, 16'h0101);

    // Long hold then release.
    set_cnt = 0;
    set_btn = 1'b1;
    step(50);
    check("hold_pulse_total", set_cnt, 1);
    check("hold_level", set_level, 1);
    set_btn = 1'b0;
    step(5);
    check("hold_release_edge5", set_level, 1);
    step(1);
    check("hold_release_edge6", set_level, 0);
    step(4);
    check("hold_no_fall_pulse", set_cnt, 1);

    // Reset with a partial count in flight and other lanes high.
    sel_sw = 2'b11;
    step(8);
    check("pre_rst_unlock_level", unlock_level, 1);
    check("pre_rst_sel_clean", sel_clean, 2'b11);
    set_btn = 1'b1;
    step(4);
    rst_n = 1'b0;
    #1;
    check("async_rst_levels", {set_level, unlock_level, sel_clean}, 0);
    check("async_rst_pulses", {set_pulse, unlock_pulse}, 0);
    step(3);
    check("held_rst_levels", {set_level, unlock_level, sel_clean}, 0);
    set_cnt    = 0;
    unl_cnt    = 0;
    unlock_btn = 1'b0;
    sel_sw     = 2'b10;
    rst_n      = 1'b1;
    step(5);
    check("post_rst_edge5_pulses", set_cnt, 0);
    check("post_rst_edge5_sel", sel_clean, 2'b00);
    step(1);
    check("post_rst_edge6_pulse", set_pulse, 1);
    check("post_rst_edge6_sel", sel_clean, 2'b10);
    step(5);
    check("post_rst_pulse_total", set_cnt, 1);
    check("post_rst_unlock_quiet", {unlock_level, 8'(unl_cnt)}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
